trigger_conditioner: RTL and testbench
======================================

# trigger_conditioner

Upstream stage for the Gray code counter. Conditions a raw, asynchronous, bouncing push-button input into a clean one-clock `trigger` pulse that drives the counter's `trigger` input. Synchronises, debounces, and emits one pulse per press. Optional hold-to-repeat issues further pulses at a fixed rate while the button stays held.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a level change is accepted; legal range >= 2.
- `REPEAT_EN`, default 0: 1 enables hold-to-repeat; 0 disables it.
- `HOLD_DELAY`, default 50000000: cycles from the first pulse to the first repeat pulse; >= 2.
- `REPEAT_PERIOD`, default 10000000: cycles between successive repeat pulses; >= 2.

Ports:
- `clk`  input  1  single system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `btn_in`  input  1  raw button, asynchronous to `clk`, active-high, may bounce.
- `btn_level`  output  1  debounced, synchronised button level.
- `trigger`  output  1  one-cycle-wide press/repeat pulse, registered.

## Operation

- Reset (`reset`=0, asynchronous): both synchroniser flops = 0, debounce counter = 0, `btn_level` = 0, FSM = IDLE, hold/repeat counter = 0, `trigger` = 0.
- Synchroniser: two flops in series on `btn_in`; the second flop output (`sync`) is the only signal used downstream.
- Debounce:
  - Counter increments each cycle while `sync` != `btn_level`, and clears to 0 whenever they are equal.
  - When the counter holds DEBOUNCE_CYCLES-1 and they still differ, `btn_level` <= `sync` and the counter clears.
  - Any single-cycle agreement restarts the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES); the counter never wraps.
- FSM, driven by `btn_level`:
  - IDLE:
    - On `btn_level` 0->1: assert `trigger` for the next cycle, clear the hold counter, go to HOLD.
  - HOLD:
    - Hold counter increments each cycle.
    - `btn_level`=0: go to IDLE with no pulse.
    - REPEAT_EN=1 and hold counter = HOLD_DELAY-1: pulse `trigger`, clear the counter, go to REPEAT.
    - REPEAT_EN=0: stays in HOLD until release; the counter saturates at HOLD_DELAY-1.
  - REPEAT:
    - Counter increments each cycle.
    - Counter = REPEAT_PERIOD-1: pulse `trigger` and clear the counter.
    - `btn_level`=0: go to IDLE with no pulse.
- Release priority: if `btn_level` is 0 in the same cycle a hold or repeat expiry would fire, release wins and no pulse is issued.
- `trigger` is never high for two consecutive cycles.
- `btn_level` falling never produces a pulse.

## Timing

- Press latency (btn_in clean-high, first sampled at edge E0):
  - `btn_level`=1 after edge E0+DEBOUNCE_CYCLES+1.
  - `trigger`=1 for exactly one cycle after edge E0+DEBOUNCE_CYCLES+2.
- Release latency is symmetric: `btn_level`=0 after edge E0+DEBOUNCE_CYCLES+1, measured from the first low sample.
- Repeat spacing:
  - First repeat pulse is HOLD_DELAY cycles after the initial pulse.
  - Each later pulse is REPEAT_PERIOD cycles after the previous one.
- Glitches shorter than DEBOUNCE_CYCLES cycles at the `sync` level produce no change on `btn_level` or `trigger`.
- Reset mid-operation:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - If the button is still held when reset deasserts, `btn_level` rises again after the full debounce latency and exactly one fresh `trigger` is issued.

## Test plan

Parameters for all scenarios: DEBOUNCE_CYCLES=4, HOLD_DELAY=20, REPEAT_PERIOD=8.

- **Clean press, REPEAT_EN=0.** `btn_in` 0->1 held 50 cycles.
  - `btn_level` rises 5 edges after first sample.
  - Exactly one `trigger` pulse, 1 cycle later.
  - `btn_level` falls 5 edges after release, with no further pulses.
- **Bounce rejection.** `btn_in` toggles 1,0,1,1,0,1 (single-cycle levels), then holds 1.
  - Zero pulses during bouncing.
  - One pulse, 4 stable cycles plus latency after the last bounce.
- **Short glitch.** `btn_in` high for 3 cycles, then low.
  - `btn_level` stays 0 and `trigger` stays 0 throughout.
- **Auto-repeat, REPEAT_EN=1.** Hold 60 cycles past `btn_level` rise.
  - Pulses at relative cycles 0, 20, 28, 36, 44, 52.
  - Releasing exactly at an expiry cycle yields no pulse.
- **Reset mid-hold.** Assert `reset`=0 for 3 cycles during REPEAT, with the button held.
  - All outputs 0 immediately.
  - After deassert, `btn_level` re-rises after 5 edges, then exactly one pulse.
- **Back-to-back presses.** Presses separated by 6 low cycles.
  - Two distinct pulses.
  - `trigger` never high on consecutive cycles.

Source files
------------

// File: rtl/trigger_conditioner.sv
// Push-button conditioner: two-flop synchroniser, stability-count debouncer and
// press/hold-to-repeat FSM producing a registered single-cycle trigger pulse.
module trigger_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 0,
  parameter int HOLD_DELAY      = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic trigger
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HC_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int HC_W   = $clog2(HC_MAX);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_DELAY - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  logic            sync1;
  logic            sync;
  logic [DB_W-1:0] db_cnt;
  logic [HC_W-1:0] hcnt;
  state_t          state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync  <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync  <= sync1;
    end
  end

  // The count only advances while the synchronised input disagrees with the
  // accepted level, so any single agreeing cycle restarts the stability window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (sync != btn_level) begin
      if (db_cnt == DB_LAST) begin
        btn_level <= sync;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Release is tested before any expiry so a release coinciding with a
  // hold/repeat expiry never emits a pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hcnt    <= '0;
      trigger <= 1'b0;
    end else begin
      trigger <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_level) begin
            trigger <= 1'b1;
            hcnt    <= '0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (!btn_level) begin
            state <= IDLE;
          end else if (hcnt == HOLD_LAST) begin
            if (REPEAT_EN != 0) begin
              trigger <= 1'b1;
              hcnt    <= '0;
              state   <= REPEAT;
            end
          end else begin
            hcnt <= hcnt + HC_W'(1);
          end
        end
        REPEAT: begin
          if (!btn_level) begin
            state <= IDLE;
          end else if (hcnt == REP_LAST) begin
            trigger <= 1'b1;
            hcnt    <= '0;
          end else begin
            hcnt <= hcnt + HC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner: one instance without and one with
// hold-to-repeat, both driven by the same button and reset.
module tb_trigger_conditioner;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic btn_in = 1'b0;
  logic lvl0, trg0, lvl1, trg1;

  int vectors     = 0;
  int miscompares = 0;

  trigger_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN      (0),
    .HOLD_DELAY     (20),
    .REPEAT_PERIOD  (8)
  ) dut0 (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_level(lvl0),
    .trigger  (trg0)
  );

  trigger_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN      (1),
    .HOLD_DELAY     (20),
    .REPEAT_PERIOD  (8)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_level(lvl1),
    .trigger  (trg1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic btn;
    logic lvl;
    logic trg0;
    logic trg1;
  } vec_t;

  vec_t tbl [76];

  int rise    [2];
  int fall    [2];
  int np      [2];
  int consec  [2];
  int pidx    [2][8];

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic b);
    btn_in = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] ones(input int unsigned lo, input int unsigned hi);
    logic [127:0] r;
    r = '0;
    for (int unsigned b = lo; b < hi; b++) r[b] = 1'b1;
    return r;
  endfunction

  // Applies pat[k] before edge k and records, per instance, the edge index of
  // the first level rise/fall, all pulse positions and back-to-back pulses.
  task automatic run(input logic [127:0] pat, input int unsigned n);
    logic pl [2];
    logic pt [2];
    logic cl [2];
    logic ct [2];
    pl[0] = lvl0; pl[1] = lvl1;
    pt[0] = trg0; pt[1] = trg1;
    for (int d = 0; d < 2; d++) begin
      rise[d] = -1; fall[d] = -1; np[d] = 0; consec[d] = 0;
      for (int j = 0; j < 8; j++) pidx[d][j] = -1;
    end
    for (int unsigned k = 0; k < n; k++) begin
      tick(pat[k]);
      cl[0] = lvl0; cl[1] = lvl1;
      ct[0] = trg0; ct[1] = trg1;
      for (int d = 0; d < 2; d++) begin
        if (cl[d] && !pl[d] && rise[d] < 0) rise[d] = int'(k);
        if (!cl[d] && pl[d] && fall[d] < 0) fall[d] = int'(k);
        if (ct[d]) begin
          if (np[d] < 8) pidx[d][np[d]] = int'(k);
          np[d]++;
          if (pt[d]) consec[d]++;
        end
        pl[d] = cl[d];
        pt[d] = ct[d];
      end
    end
  endtask

  initial begin
    // Held press: first high sample at vector 0, release sampled at vector 66.
    for (int i = 0; i < 76; i++) begin
      tbl[i].btn  = (i < 66);
      tbl[i].lvl  = (i >= 5) && (i < 71);
      tbl[i].trg0 = (i == 6);
      tbl[i].trg1 = (i inside {6, 26, 34, 42, 50, 58, 66});
    end

    reset  = 1'b0;
    btn_in = 1'b0;
    #12;
    check("reset_lvl0", int'(lvl0), 0);
    check("reset_trg0", int'(trg0), 0);
    check("reset_lvl1", int'(lvl1), 0);
    check("reset_trg1", int'(trg1), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0);
    check("idle_lvl0", int'(lvl0), 0);
    check("idle_trg1", int'(trg1), 0);

    for (int i = 0; i < 76; i++) begin
      tick(tbl[i].btn);
      check($sformatf("tbl[%0d].lvl0", i), int'(lvl0), int'(tbl[i].lvl));
      check($sformatf("tbl[%0d].lvl1", i), int'(lvl1), int'(tbl[i].lvl));
      check($sformatf("tbl[%0d].trg0", i), int'(trg0), int'(tbl[i].trg0));
      check($sformatf("tbl[%0d].trg1", i), int'(trg1), int'(tbl[i].trg1));
    end

    // Bounce 1,0,1,1,0 then stable high from index 5, released at 24.
    begin
      logic [127:0] p;
      p = ones(5, 24);
      p[0] = 1'b1; p[2] = 1'b1; p[3] = 1'b1;
      run(p, 40);
    end
    check("bounce_rise0", rise[0], 10);
    check("bounce_np0", np[0], 1);
    check("bounce_pulse0", pidx[0][0], 11);
    check("bounce_np1", np[1], 1);
    check("bounce_fall1", fall[1], 29);

    run(ones(0, 3), 15);
    check("glitch_rise0", rise[0], -1);
    check("glitch_rise1", rise[1], -1);
    check("glitch_np0", np[0], 0);
    check("glitch_np1", np[1], 0);

    // Level falls just before the hold expiry edge.
    run(ones(0, 20), 35);
    check("hold_exp_fall1", fall[1], 25);
    check("hold_exp_np1", np[1], 1);
    check("hold_exp_pulse1", pidx[1][0], 6);

    // Level falls just before the second repeat expiry edge.
    run(ones(0, 28), 45);
    check("rep_exp_np1", np[1], 2);
    check("rep_exp_p1_1", pidx[1][1], 26);
    check("rep_exp_np0", np[0], 1);
    check("rep_exp_fall0", fall[0], 33);

    run(ones(0, 10) | ones(16, 26), 45);
    check("b2b_np0", np[0], 2);
    check("b2b_p0_0", pidx[0][0], 6);
    check("b2b_p0_1", pidx[0][1], 22);
    check("b2b_fall0", fall[0], 15);
    check("b2b_np1", np[1], 2);
    check("b2b_p1_1", pidx[1][1], 22);
    check("b2b_consec0", consec[0], 0);
    check("b2b_consec1", consec[1], 0);

    // Stop on the first repeat pulse, then reset asynchronously mid-cycle.
    run(ones(0, 27), 27);
    check("prerst_np1", np[1], 2);
    check("prerst_trg1", int'(trg1), 1);
    check("prerst_lvl1", int'(lvl1), 1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_lvl0", int'(lvl0), 0);
    check("rst_async_lvl1", int'(lvl1), 0);
    check("rst_async_trg0", int'(trg0), 0);
    check("rst_async_trg1", int'(trg1), 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_lvl1", int'(lvl1), 0);
    reset = 1'b1;
    run(ones(0, 20), 20);
    check("rerise_rise0", rise[0], 5);
    check("rerise_rise1", rise[1], 5);
    check("rerise_np0", np[0], 1);
    check("rerise_np1", np[1], 1);
    check("rerise_pulse1", pidx[1][0], 6);
    run('0, 12);
    check("final_np1", np[1], 0);
    check("final_lvl0", int'(lvl0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
